// File: rtl/decrypt_arbiter_if.sv
// decrypt_arbiter_if: key load, two requester channels, output stage and counters of decrypt_arbiter
interface decrypt_arbiter_if #(
    parameter int CNT_W = 16
);
    logic             key_load;
    logic             key_chan;
    logic [7:0]       key_in;
    logic             valid_a;
    logic [7:0]       msg_a;
    logic             ready_a;
    logic             valid_b;
    logic [7:0]       msg_b;
    logic             ready_b;
    logic             out_valid;
    logic             out_ready;
    logic [7:0]       out_data;
    logic             out_chan;
    logic [CNT_W-1:0] cnt_a;
    logic [CNT_W-1:0] cnt_b;

    modport slave (
        input  key_load, key_chan, key_in, valid_a, msg_a, valid_b, msg_b, out_ready,
        output ready_a, ready_b, out_valid, out_data, out_chan, cnt_a, cnt_b
    );

    modport master (
        output key_load, key_chan, key_in, valid_a, msg_a, valid_b, msg_b, out_ready,
        input  ready_a, ready_b, out_valid, out_data, out_chan, cnt_a, cnt_b
    );
endinterface

// File: rtl/decrypt_arbiter.sv
// decrypt_arbiter: round-robin sharing of one byte decryptor between two keyed channels
module decrypt_arbiter #(
    parameter logic [7:0] KEY_A_RST = 8'h00,
    parameter logic [7:0] KEY_B_RST = 8'h00,
    parameter int         CNT_W     = 16
) (
    input logic              clk,
    input logic              rst_n,
    decrypt_arbiter_if.slave bus
);
    typedef enum logic {EMPTY, FULL} state_t;

    state_t           state_q;
    logic [7:0]       key_a_q, key_b_q, data_q, mix, data_d;
    logic             last_b_q, chan_q, space, accept;
    logic [CNT_W-1:0] cnt_a_q, cnt_b_q;

    // lastGrant resets to B so A wins the first tie
    assign space       = state_q == EMPTY || bus.out_ready;
    assign bus.ready_a = space && bus.valid_a && (!bus.valid_b || last_b_q);
    assign bus.ready_b = space && bus.valid_b && (!bus.valid_a || !last_b_q);
    assign accept      = bus.ready_a || bus.ready_b;
    assign mix         = bus.ready_b ? bus.msg_b ^ key_b_q : bus.msg_a ^ key_a_q;
    assign data_d      = {bus.ready_b ? bus.msg_b[7] : bus.msg_a[7],
                          ~mix[6], mix[3], ~mix[4], mix[1], ~mix[2], mix[5], ~mix[0]};

    assign bus.out_valid = state_q == FULL;
    assign bus.out_data  = data_q;
    assign bus.out_chan  = chan_q;
    assign bus.cnt_a     = cnt_a_q;
    assign bus.cnt_b     = cnt_b_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= EMPTY;
            data_q   <= '0;
            chan_q   <= 1'b0;
            last_b_q <= 1'b1;
            key_a_q  <= KEY_A_RST;
            key_b_q  <= KEY_B_RST;
            cnt_a_q  <= '0;
            cnt_b_q  <= '0;
        end else begin
            if (bus.key_load && !bus.key_chan) key_a_q <= bus.key_in;
            if (bus.key_load && bus.key_chan) key_b_q <= bus.key_in;
            if (accept) begin
                state_q  <= FULL;
                data_q   <= data_d;
                chan_q   <= bus.ready_b;
                last_b_q <= bus.ready_b;
            end else if (bus.out_ready) begin
                state_q <= EMPTY;
            end
            if (bus.ready_a) cnt_a_q <= cnt_a_q + CNT_W'(1);
            if (bus.ready_b) cnt_b_q <= cnt_b_q + CNT_W'(1);
        end
    end
endmodule
